// File: rtl/picosoc_mem_arbiter_if.sv
// picosoc_mem_arbiter_if: two-master/one-slave picoRV32 native bus bundle plus arbiter status.
interface picosoc_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  m0_valid;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [31:0]           m0_wdata;
    logic [3:0]            m0_wstrb;
    logic                  m0_ready;
    logic [31:0]           m0_rdata;
    logic                  m1_valid;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [31:0]           m1_wdata;
    logic [3:0]            m1_wstrb;
    logic                  m1_ready;
    logic [31:0]           m1_rdata;
    logic                  s_valid;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_ready;
    logic [31:0]           s_rdata;
    logic [1:0]            grant;
    logic                  timeout_pulse;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  s_ready, s_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        output grant, timeout_pulse
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output s_ready, s_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        input  grant, timeout_pulse
    );
endinterface

// File: rtl/picosoc_mem_arbiter.sv
// picosoc_mem_arbiter: round-robin arbiter sharing one picoRV32 slave between two masters,
// holding each grant for one transaction and aborting stalled ones after TIMEOUT_CYCLES.
module picosoc_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input logic clk,
    input logic reset,
    picosoc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    localparam bit          TO_EN  = TIMEOUT_CYCLES != 0;
    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  busy, own1, o_valid, done, to_hit, end_x;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [31:0]           rdata_sel;

    always_comb begin
        busy      = state_q != IDLE;
        own1      = state_q == OWN1;
        o_valid   = busy && (own1 ? bus.m1_valid : bus.m0_valid);
        done      = o_valid && bus.s_ready;
        // the count includes the current stalled cycle, so abort lands in cycle TIMEOUT_CYCLES
        to_hit    = TO_EN && o_valid && !bus.s_ready && ({1'b0, cnt_q} + 17'd1 == TO_LIM);
        end_x     = done || to_hit;
        addr_sel  = !busy ? '0 : own1 ? bus.m1_addr : bus.m0_addr;
        rdata_sel = to_hit ? TIMEOUT_RDATA : bus.s_rdata;
    end

    assign bus.s_valid       = o_valid && !to_hit;
    assign bus.s_addr        = addr_sel;
    assign bus.s_wdata       = !busy ? 32'd0 : own1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.s_wstrb       = !busy ? 4'd0 : own1 ? bus.m1_wstrb : bus.m0_wstrb;
    assign bus.m0_ready      = state_q == OWN0 && end_x;
    assign bus.m1_ready      = own1 && end_x;
    assign bus.m0_rdata      = state_q == OWN0 ? rdata_sel : 32'd0;
    assign bus.m1_rdata      = own1 ? rdata_sel : 32'd0;
    assign bus.grant         = {own1, state_q == OWN0};
    assign bus.timeout_pulse = to_hit;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        if (!busy)
            state_d = (bus.m0_valid && bus.m1_valid) ? (last_q ? OWN0 : OWN1) :
                      bus.m0_valid ? OWN0 : bus.m1_valid ? OWN1 : IDLE;
        else if (!o_valid || end_x)
            state_d = IDLE;
        last_d = end_x ? own1 : last_q;
        cnt_d  = (o_valid && !end_x) ? cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// tb_picosoc_mem_arbiter: directed scenario tasks with hand-computed expectations for the arbiter.
module tb_picosoc_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    picosoc_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    picosoc_mem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
        bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
        bus.s_ready = 0; bus.s_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        bus.m0_valid = 1; bus.m0_addr = 32'h40; bus.s_ready = 1; bus.s_rdata = 32'h1111_1111;
        tick();
        tick();
        total++;
        if ({bus.grant, bus.s_valid, bus.m0_ready, bus.m1_ready, bus.timeout_pulse} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {bus.grant, bus.s_valid, bus.m0_ready, bus.m1_ready, bus.timeout_pulse});
        end
        total++;
        if ({bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_rdata, bus.m1_rdata} !== 132'd0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_rdata, bus.m1_rdata});
        end
        clear_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_single();
        bus.m0_valid = 1; bus.m0_addr = 32'h0000_0100;
        #1;
        total++;
        if ({bus.grant, bus.s_valid} !== 3'b000) begin
            bad++; $display("FAIL single_idle got=%b exp=000", {bus.grant, bus.s_valid});
        end
        tick();
        total++;
        if ({bus.grant, bus.s_valid, bus.m0_ready, bus.s_addr, bus.s_wstrb} !== {2'b01, 1'b1, 1'b0, 32'h0000_0100, 4'h0}) begin
            bad++;
            $display("FAIL single_fwd got=%h exp=%h", {bus.grant, bus.s_valid, bus.m0_ready, bus.s_addr, bus.s_wstrb},
                     {2'b01, 1'b1, 1'b0, 32'h0000_0100, 4'h0});
        end
        bus.s_ready = 1; bus.s_rdata = 32'h1234_5678;
        #1;
        total++;
        if ({bus.m0_ready, bus.m0_rdata, bus.m1_ready, bus.m1_rdata, bus.timeout_pulse} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL single_ready got=%h exp=%h", {bus.m0_ready, bus.m0_rdata, bus.m1_ready, bus.m1_rdata, bus.timeout_pulse},
                     {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0});
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if ({bus.grant, bus.m0_ready, bus.m0_rdata} !== 35'd0) begin
            bad++; $display("FAIL single_after got=%h exp=0", {bus.grant, bus.m0_ready, bus.m0_rdata});
        end
    endtask

    task automatic test_contention();
        reset = 1;
        tick();
        reset = 0;
        bus.m0_valid = 1; bus.m0_addr = 32'h10;
        bus.m1_valid = 1; bus.m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_g;
            logic [31:0] exp_a;
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_a = exp_g[0] ? 32'h10 : 32'h20;
            #1;
            total++;
            if (bus.grant !== 2'b00) begin
                bad++; $display("FAIL cont_idle[%0d] got=%b exp=00", i, bus.grant);
            end
            tick();
            total++;
            if ({bus.grant, bus.s_valid, bus.s_addr} !== {exp_g, 1'b1, exp_a}) begin
                bad++; $display("FAIL cont_grant[%0d] got=%h exp=%h", i, {bus.grant, bus.s_valid, bus.s_addr}, {exp_g, 1'b1, exp_a});
            end
            bus.s_ready = 1;
            #1;
            total++;
            if ({bus.m1_ready, bus.m0_ready} !== exp_g) begin
                bad++; $display("FAIL cont_ready[%0d] got=%b exp=%b", i, {bus.m1_ready, bus.m0_ready}, exp_g);
            end
            tick();
            bus.s_ready = 0;
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_write();
        bus.m1_valid = 1; bus.m1_addr = 32'h0200_0008; bus.m1_wdata = 32'hA5A5_0000; bus.m1_wstrb = 4'b0011;
        #1;
        total++;
        if ({bus.m0_ready, bus.s_valid} !== 2'b00) begin
            bad++; $display("FAIL write_idle got=%b exp=00", {bus.m0_ready, bus.s_valid});
        end
        tick();
        total++;
        if ({bus.grant, bus.s_valid, bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_ready} !==
            {2'b10, 1'b1, 32'h0200_0008, 32'hA5A5_0000, 4'b0011, 1'b0}) begin
            bad++;
            $display("FAIL write_fwd got=%h exp=%h", {bus.grant, bus.s_valid, bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_ready},
                     {2'b10, 1'b1, 32'h0200_0008, 32'hA5A5_0000, 4'b0011, 1'b0});
        end
        tick();
        bus.s_ready = 1;
        #1;
        total++;
        if ({bus.m1_ready, bus.m0_ready, bus.timeout_pulse} !== 3'b100) begin
            bad++; $display("FAIL write_ready got=%b exp=100", {bus.m1_ready, bus.m0_ready, bus.timeout_pulse});
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if ({bus.grant, bus.m0_ready, bus.m1_ready} !== 4'b0) begin
            bad++; $display("FAIL write_after got=%b exp=0000", {bus.grant, bus.m0_ready, bus.m1_ready});
        end
    endtask

    task automatic test_timeout();
        bus.m0_valid = 1; bus.m0_addr = 32'h300;
        tick();
        for (int c = 1; c <= 3; c++) begin
            total++;
            if ({bus.s_valid, bus.m0_ready, bus.timeout_pulse} !== 3'b100) begin
                bad++; $display("FAIL to_stall[%0d] got=%b exp=100", c, {bus.s_valid, bus.m0_ready, bus.timeout_pulse});
            end
            tick();
        end
        total++;
        if ({bus.grant, bus.s_valid, bus.m0_ready, bus.m0_rdata, bus.timeout_pulse} !== {2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1}) begin
            bad++;
            $display("FAIL to_abort got=%h exp=%h", {bus.grant, bus.s_valid, bus.m0_ready, bus.m0_rdata, bus.timeout_pulse},
                     {2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1});
        end
        tick();
        bus.m0_valid = 0;
        #1;
        total++;
        if ({bus.grant, bus.timeout_pulse, bus.m0_ready} !== 4'b0) begin
            bad++; $display("FAIL to_idle got=%b exp=0000", {bus.grant, bus.timeout_pulse, bus.m0_ready});
        end
        bus.m0_valid = 1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            total++;
            if ({bus.s_valid, bus.timeout_pulse} !== 2'b10) begin
                bad++; $display("FAIL to2_stall[%0d] got=%b exp=10", c, {bus.s_valid, bus.timeout_pulse});
            end
            tick();
        end
        bus.s_ready = 1; bus.s_rdata = 32'hCAFE_F00D;
        #1;
        total++;
        if ({bus.s_valid, bus.m0_ready, bus.m0_rdata, bus.timeout_pulse} !== {1'b1, 1'b1, 32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL to_race got=%h exp=%h", {bus.s_valid, bus.m0_ready, bus.m0_rdata, bus.timeout_pulse},
                     {1'b1, 1'b1, 32'hCAFE_F00D, 1'b0});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.m1_valid = 1; bus.m1_addr = 32'h400;
        tick();
        total++;
        if (bus.grant !== 2'b10) begin
            bad++; $display("FAIL rmid_own got=%b exp=10", bus.grant);
        end
        tick();
        reset = 1;
        bus.m0_valid = 1; bus.m0_addr = 32'h500;
        tick();
        total++;
        if ({bus.grant, bus.s_valid, bus.m1_ready, bus.m0_ready} !== 5'b0) begin
            bad++; $display("FAIL rmid_cut got=%b exp=00000", {bus.grant, bus.s_valid, bus.m1_ready, bus.m0_ready});
        end
        reset = 0;
        tick();
        total++;
        if ({bus.grant, bus.s_addr} !== {2'b01, 32'h500}) begin
            bad++; $display("FAIL rmid_win got=%h exp=%h", {bus.grant, bus.s_addr}, {2'b01, 32'h500});
        end
        bus.s_ready = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_valid_drop();
        bus.m1_valid = 1;
        tick();
        bus.s_ready = 1;
        tick();
        clear_inputs();
        bus.m0_valid = 1;
        tick();
        total++;
        if (bus.grant !== 2'b01) begin
            bad++; $display("FAIL drop_own got=%b exp=01", bus.grant);
        end
        bus.m0_valid = 0;
        #1;
        total++;
        if ({bus.s_valid, bus.m0_ready} !== 2'b00) begin
            bad++; $display("FAIL drop_out got=%b exp=00", {bus.s_valid, bus.m0_ready});
        end
        tick();
        total++;
        if ({bus.grant, bus.m0_ready} !== 3'b000) begin
            bad++; $display("FAIL drop_idle got=%b exp=000", {bus.grant, bus.m0_ready});
        end
        bus.m0_valid = 1; bus.m1_valid = 1;
        tick();
        total++;
        if (bus.grant !== 2'b01) begin
            bad++; $display("FAIL drop_last got=%b exp=01", bus.grant);
        end
        bus.s_ready = 1;
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_write();
        test_timeout();
        test_reset_mid();
        test_valid_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
